// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory access controller
// Contents: imem_state_e (BOOT/RUN), NOP_INSTR (word returned on rejected fetches), imem_word_t.
package imem_pkg;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } imem_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [31:0] imem_word_t;

endpackage

// File: rtl/imem_access_ctrl_if.sv
// rtl/imem_access_ctrl_if.sv - fetch, loader and memory-port bundle of the instruction memory controller
// Modports: slave  = controller view (consumes requests/read data, drives grants/responses/memory controls)
//           master = environment view (fetch unit, loader and memory model)
// Optional: IMEM_BOUNDS_CHK_EN adds load_err_o.
interface imem_access_ctrl_if;
    import imem_pkg::*;

    logic       fetch_req_i;
    imem_word_t fetch_addr_i;
    logic       fetch_gnt_o;
    logic       fetch_rvalid_o;
    imem_word_t fetch_rdata_o;
    logic       fetch_err_o;

    logic       load_req_i;
    imem_word_t load_addr_i;
    imem_word_t load_data_i;
    logic       load_gnt_o;
    logic       load_done_i;
    logic       boot_done_o;
`ifdef IMEM_BOUNDS_CHK_EN
    logic       load_err_o;
`endif

    imem_word_t mem_addr_o;
    imem_word_t mem_wdata_o;
    logic       mem_we_o;
    logic       mem_re_o;
    imem_word_t mem_rdata_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_data_i,
               load_done_i, mem_rdata_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
               load_gnt_o, boot_done_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
`ifdef IMEM_BOUNDS_CHK_EN
        , output load_err_o
`endif
    );

    modport master (
        output fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_data_i,
               load_done_i, mem_rdata_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
               load_gnt_o, boot_done_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
`ifdef IMEM_BOUNDS_CHK_EN
        , input load_err_o
`endif
    );

endinterface

// File: rtl/imem_starve_cnt.sv
// rtl/imem_starve_cnt.sv - saturating count of consecutive denied loader requests
// Ports: clk_i, rst_ni (async, active-low), inc_i (request denied this cycle),
//        clr_i (granted or not requesting; wins over inc_i), sat_o (count reached MAX_WAIT).
module imem_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat_o = (cnt_q == LIMIT);

endmodule

// File: rtl/imem_access_ctrl.sv
// rtl/imem_access_ctrl.sv - boot sequencing and fetch/load arbitration for the instruction memory port
// Ports: clk_i, rst_ni (async, active-low), bus (imem_access_ctrl_if.slave: fetch request/grant/response,
//        loader request/grant/done, boot_done_o, memory address/wdata/we/re and combinational read data).
// Optional: define IMEM_BOUNDS_CHK_EN to reject word indexes >= NENTRIES like misaligned accesses
//           and to drive load_err_o on every dropped load grant.
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter int NENTRIES = 128,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    imem_access_ctrl_if.slave   bus
);

    imem_state_e state_q, state_d;
    logic        fetch_gnt, load_gnt;
    logic        fetch_bad, load_bad;
    logic        starved;
    logic        rvalid_q, err_q;
    imem_word_t  rdata_q;

    // Rejected accesses are still granted so neither requester stalls on a bad address;
    // they simply never reach the memory array.
`ifdef IMEM_BOUNDS_CHK_EN
    localparam logic [29:0] IDX_LIMIT = 30'(NENTRIES);
    assign fetch_bad = (bus.fetch_addr_i[1:0] != 2'b00) || (bus.fetch_addr_i[31:2] >= IDX_LIMIT);
    assign load_bad  = (bus.load_addr_i[1:0]  != 2'b00) || (bus.load_addr_i[31:2]  >= IDX_LIMIT);
`else
    assign fetch_bad = (bus.fetch_addr_i[1:0] != 2'b00);
    assign load_bad  = (bus.load_addr_i[1:0]  != 2'b00);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving BOOT waits for an idle loader so a final write that coincides with done still lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    if (bus.load_done_i && !bus.load_req_i) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        case (state_q)
            BOOT: load_gnt = bus.load_req_i;
            RUN: begin
                if (bus.load_req_i && starved) begin
                    load_gnt = 1'b1;
                end else if (bus.fetch_req_i) begin
                    fetch_gnt = 1'b1;
                end else if (bus.load_req_i) begin
                    load_gnt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Only RUN can deny the loader, so BOOT never advances the count.
    imem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  ((state_q == RUN) && bus.load_req_i && !load_gnt),
        .clr_i  (load_gnt || !bus.load_req_i),
        .sat_o  (starved)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= fetch_gnt;
            err_q    <= fetch_gnt && fetch_bad;
            if (fetch_gnt) begin
                rdata_q <= fetch_bad ? NOP_INSTR : bus.mem_rdata_i;
            end
        end
    end

    assign bus.fetch_gnt_o    = fetch_gnt;
    assign bus.load_gnt_o     = load_gnt;
    assign bus.boot_done_o    = (state_q == RUN);
    assign bus.fetch_rvalid_o = rvalid_q;
    assign bus.fetch_err_o    = err_q;
    assign bus.fetch_rdata_o  = rdata_q;
    assign bus.mem_re_o       = fetch_gnt && !fetch_bad;
    assign bus.mem_we_o       = load_gnt && !load_bad;
    assign bus.mem_addr_o     = fetch_gnt ? bus.fetch_addr_i :
                                load_gnt  ? bus.load_addr_i  : '0;
    assign bus.mem_wdata_o    = load_gnt ? bus.load_data_i : '0;
`ifdef IMEM_BOUNDS_CHK_EN
    assign bus.load_err_o     = load_gnt && load_bad;
`endif

endmodule
